opll_bus_sequencer: RTL
=======================

Name: opll_bus_sequencer

Overview:
- Paced register-write front-end for one or more IKAOPLL cores in the tt_um top.
- Accepts {chip, register, data} write commands via valid/ready and buffers them in a FIFO.
- Replays each command as a YM2413-legal CS_n/WR_n/A0/D bus sequence, enforcing the post-address and post-data wait times, so host pins no longer bit-bang the bus.
- Generalises the single-chip, directly-wired bus of the current top to N chips with a queue and timing enforcement.

Parameters:
- NUM_CHIPS, 1: number of OPLL instances; one CS_n line each.
- FIFO_DEPTH, 8: command FIFO entries; power of two, at least 2.
- WR_PULSE, 4: clk cycles WR_n is held low per strobe; at least 1.
- ADDR_WAIT, 12: clk cycles idle after an address strobe, before the data phase.
- DATA_WAIT, 84: clk cycles idle after a data strobe, before the next command.

Ports:
- clk  in  1  single clock, the same clock as IKAOPLL i_XIN_EMUCLK.
- rst  in  1  asynchronous, active-high reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  FIFO not full.
- i_cmd_chip  in  CW  target chip index; CW = max(1, clog2(NUM_CHIPS)).
- i_cmd_reg  in  8  OPLL register address.
- i_cmd_data  in  8  OPLL register data.
- o_cs_n  out  NUM_CHIPS  per-chip chip-select, active low.
- o_wr_n  out  1  write strobe, active low.
- o_a0  out  1  0 = address phase, 1 = data phase.
- o_d  out  8  bus data.
- o_busy  out  1  FSM not IDLE, or FIFO not empty.
- o_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- o_bad_chip  out  1  sticky flag: a command named a chip index of NUM_CHIPS or higher.

Behaviour:
- Reset values: o_cs_n all 1, o_wr_n 1, o_a0 0, o_d 0, o_busy 0, o_level 0, o_bad_chip 0. FIFO is emptied and FSM goes to IDLE.
- Reset asserted mid-transaction aborts immediately. Outputs return to their reset values asynchronously; no partial strobe completes.
- Handshake:
  - A command is pushed on a clk edge where i_cmd_valid and o_cmd_ready are both 1.
  - o_cmd_ready = (level < FIFO_DEPTH).
  - A push and a pop in the same cycle leave the level unchanged and are legal when full.
- Bad chip index: the command is still accepted and consumed, but never driven on the bus (no CS asserted). o_bad_chip is set and stays set until reset.
- All bus outputs are registered. States and the registered outputs valid during them:
  - IDLE: CS all 1, WR_n 1. On FIFO non-empty, latch the head entry, pop it, and go to A_SETUP.
  - A_SETUP (1 cycle): CS[chip]=0, A0=0, D=reg, WR_n=1.
  - A_STROBE (WR_PULSE cycles): as A_SETUP but WR_n=0.
  - A_WAIT (ADDR_WAIT cycles): WR_n=1, CS=1; A0 and D hold their values.
  - D_SETUP (1 cycle): CS[chip]=0, A0=1, D=data, WR_n=1.
  - D_STROBE (WR_PULSE cycles): as D_SETUP but WR_n=0.
  - D_WAIT (DATA_WAIT cycles): WR_n=1, CS=1. Then go to IDLE.
- Counter: one down-counter sized for max(WR_PULSE, ADDR_WAIT, DATA_WAIT). It is loaded on every state entry; the state exits when the counter reaches 0.
- Timing:
  - Full transaction = 2 + 2*WR_PULSE + ADDR_WAIT + DATA_WAIT cycles (106 with defaults).
  - IDLE costs one cycle between consecutive commands.
  - First A_SETUP appears on the bus 2 cycles after the accepting edge when the FIFO was empty.
- Commands are issued strictly in FIFO order; there is no reordering across chips.
- o_d changes only in the SETUP states, so data is stable for the whole of every WR_n low period.

Optional Feature:
- OPLL_ADDR_CACHE_EN defined:
  - The block remembers the last register address written per chip; these are invalid after reset.
  - If the head command targets a valid cached address, IDLE jumps directly to D_SETUP, and A_SETUP/A_STROBE/A_WAIT are skipped.
  - The cache entry is updated when A_STROBE completes.
  - A bad-chip command does not touch the cache.
- Not defined: every command runs the full address and data sequence. The cache logic is absent.

Decomposition:
- Package opll_bus_pkg:
  - state enum opll_bus_state_t (IDLE, A_SETUP, A_STROBE, A_WAIT, D_SETUP, D_STROBE, D_WAIT);
  - default timing constants OPLL_ADDR_WAIT_DEF=12, OPLL_DATA_WAIT_DEF=84, OPLL_WR_PULSE_DEF=4;
  - packed command struct {chip, reg, data}.
- Sub-module opll_cmd_fifo: synchronous FIFO with level output, parametrised by depth and width. The FSM and counter stay in opll_bus_sequencer.

Test Plan:
- Single write, defaults: push chip0 reg 0x10 data 0x55.
  - WR_n low 4 cycles with A0=0, D=0x10.
  - 12 idle cycles.
  - WR_n low 4 cycles with A0=1, D=0x55.
  - o_busy drops exactly 106 cycles after the first A_SETUP.
- Back-to-back: push 8 commands with FIFO_DEPTH=8.
  - o_cmd_ready drops only when level=8.
  - Bus order matches push order.
  - Consecutive A_SETUPs are 107 cycles apart.
- NUM_CHIPS=2: push chip1 reg 0x20 data 0x0F, then chip0 reg 0x30 data 0xF0.
  - Only o_cs_n[1] goes low for the first command, then only o_cs_n[0] for the second.
- Bad chip, NUM_CHIPS=3: push chip index 3.
  - No CS asserted during its transaction.
  - o_bad_chip=1 and stays 1.
  - The next valid command executes normally.
- Reset mid-D_STROBE: assert rst.
  - Same cycle: WR_n=1, CS all 1, level=0.
  - After release: idle until a new push.
- OPLL_ADDR_CACHE_EN: push chip0 0x10/0x01, then chip0 0x10/0x02.
  - Second command shows no A0=0 strobe.
  - Its D_SETUP starts one cycle after IDLE.
  - Then push chip0 0x11/0x03: the address phase reappears.

Source files
------------

// File: rtl/opll_bus_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// opll_bus_pkg
// Shared types and constants for the OPLL bus sequencer.
//   opll_bus_state_t : bus sequencer FSM states
//   opll_cmd_t       : one queued register write {chip, addr, data}
//   OPLL_*_DEF       : default bus timing in clk cycles
// The chip field is a fixed 8 bits so the struct does not depend on NUM_CHIPS;
// narrower chip indices are zero-extended into it.
// -----------------------------------------------------------------------------
package opll_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_SETUP,
        A_STROBE,
        A_WAIT,
        D_SETUP,
        D_STROBE,
        D_WAIT
    } opll_bus_state_t;

    localparam int OPLL_ADDR_WAIT_DEF = 12;
    localparam int OPLL_DATA_WAIT_DEF = 84;
    localparam int OPLL_WR_PULSE_DEF  = 4;

    typedef struct packed {
        logic [7:0] chip;
        logic [7:0] addr;
        logic [7:0] data;
    } opll_cmd_t;

    function automatic int opll_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/opll_bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// opll_bus_sequencer_if
// Command handshake plus the YM2413-style write bus.
//   i_cmd_valid/o_cmd_ready : command handshake
//   i_cmd_chip/reg/data     : command payload (chip index is CW bits)
//   o_cs_n[NUM_CHIPS]       : per-chip select, active low
//   o_wr_n, o_a0, o_d       : write strobe, address/data select, data bus
// slave  : the sequencer side.  master : the host / bench side.
// -----------------------------------------------------------------------------
interface opll_bus_sequencer_if #(
    parameter int NUM_CHIPS = 1
) ();
    localparam int CW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;

    logic                 i_cmd_valid;
    logic                 o_cmd_ready;
    logic [CW-1:0]        i_cmd_chip;
    logic [7:0]           i_cmd_reg;
    logic [7:0]           i_cmd_data;
    logic [NUM_CHIPS-1:0] o_cs_n;
    logic                 o_wr_n;
    logic                 o_a0;
    logic [7:0]           o_d;

    modport slave (
        input  i_cmd_valid, i_cmd_chip, i_cmd_reg, i_cmd_data,
        output o_cmd_ready, o_cs_n, o_wr_n, o_a0, o_d
    );

    modport master (
        output i_cmd_valid, i_cmd_chip, i_cmd_reg, i_cmd_data,
        input  o_cmd_ready, o_cs_n, o_wr_n, o_a0, o_d
    );
endinterface

// File: rtl/opll_bus_sequencer_cmd_fifo.sv
// -----------------------------------------------------------------------------
// opll_cmd_fifo
// Synchronous FIFO with occupancy output; DEPTH must be a power of two >= 2.
//   clk, rst   : clock, asynchronous active-high reset (pointers/level only)
//   push_i     : write wdata_i (accepted when not full, or when popping)
//   pop_i      : drop the head entry (ignored when empty)
//   rdata_o    : head entry, valid while !empty_o
//   empty_o, full_o, level_o : status
// -----------------------------------------------------------------------------
module opll_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rptr_q];

    // A simultaneous pop frees the slot being written, so push is legal when full.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end
endmodule

// File: rtl/opll_bus_sequencer.sv
// -----------------------------------------------------------------------------
// opll_bus_sequencer
// Queues {chip, reg, data} writes and replays each one as a paced
// CS_n/WR_n/A0/D sequence for one or more YM2413/IKAOPLL cores.
//   clk, rst   : clock (IKAOPLL emulation clock), async active-high reset
//   bus        : opll_bus_sequencer_if.slave (command handshake + write bus)
//   o_busy     : FSM active or commands queued
//   o_level    : FIFO occupancy
//   o_bad_chip : sticky, set when a command named chip >= NUM_CHIPS
// Optional: define OPLL_ADDR_CACHE_EN to skip the address phase when the
// target chip's last written register equals the new one.
// Bus outputs are decoded from the current state into registers, so the bus
// trails the FSM by one cycle; o_busy is registered the same way so it lines
// up with the bus. All wait parameters must be >= 1.
// -----------------------------------------------------------------------------
module opll_bus_sequencer
    import opll_bus_pkg::*;
#(
    parameter int NUM_CHIPS  = 1,
    parameter int FIFO_DEPTH = 8,
    parameter int WR_PULSE   = OPLL_WR_PULSE_DEF,
    parameter int ADDR_WAIT  = OPLL_ADDR_WAIT_DEF,
    parameter int DATA_WAIT  = OPLL_DATA_WAIT_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    opll_bus_sequencer_if.slave         bus,
    output logic                        o_busy,
    output logic [$clog2(FIFO_DEPTH):0] o_level,
    output logic                        o_bad_chip
);
    localparam int CW      = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1;
    localparam int CNT_MAX = opll_max3(WR_PULSE, ADDR_WAIT, DATA_WAIT);
    localparam int CNTW    = $clog2(CNT_MAX + 1);

    typedef logic [CNTW-1:0] cnt_t;
    // Counter holds remaining cycles minus one; the state exits at zero.
    localparam cnt_t CNT_PULSE = cnt_t'(WR_PULSE - 1);
    localparam cnt_t CNT_AWAIT = cnt_t'(ADDR_WAIT - 1);
    localparam cnt_t CNT_DWAIT = cnt_t'(DATA_WAIT - 1);

    opll_bus_state_t      state_q, state_d;
    cnt_t                 cnt_q, cnt_d;
    opll_cmd_t            cmd_q, head, wcmd;
    logic                 fifo_empty, fifo_full, push, pop, hit;
    logic                 busy_q, bad_q, wr_n_q, a0_q;
    logic [7:0]           d_q;
    logic [NUM_CHIPS-1:0] cs_n_q;

    function automatic logic chip_ok(input logic [7:0] chip);
        return {1'b0, chip} < 9'(NUM_CHIPS);
    endfunction

    // Out-of-range chip indices yield an all-ones mask: nothing is selected.
    function automatic logic [NUM_CHIPS-1:0] cs_mask(input logic [7:0] chip);
        logic [NUM_CHIPS-1:0] m;
        for (int i = 0; i < NUM_CHIPS; i++) m[i] = (chip != 8'(i));
        return m;
    endfunction

    assign wcmd = '{chip: 8'(bus.i_cmd_chip), addr: bus.i_cmd_reg, data: bus.i_cmd_data};
    assign bus.o_cmd_ready = !fifo_full;
    assign push = bus.i_cmd_valid && !fifo_full;
    assign pop  = (state_q == IDLE) && !fifo_empty;

    opll_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(opll_cmd_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wcmd),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (o_level)
    );

`ifdef OPLL_ADDR_CACHE_EN
    logic [NUM_CHIPS-1:0] cvld_q;
    logic [7:0]           caddr_q [NUM_CHIPS];
    logic                 cache_upd;

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_CHIPS; i++)
            if (head.chip == 8'(i) && cvld_q[i] && caddr_q[i] == head.addr) hit = 1'b1;
    end

    // The address is known to be in the chip once its strobe has finished.
    assign cache_upd = (state_q == A_STROBE) && (cnt_q == '0) && chip_ok(cmd_q.chip);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cvld_q <= '0;
        end else if (cache_upd) begin
            for (int i = 0; i < NUM_CHIPS; i++)
                if (cmd_q.chip == 8'(i)) cvld_q[i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cache_upd)
            for (int i = 0; i < NUM_CHIPS; i++)
                if (cmd_q.chip == 8'(i)) caddr_q[i] <= cmd_q.addr;
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q != IDLE && cnt_q != '0) begin
            cnt_d = cnt_q - cnt_t'(1);
        end else begin
            case (state_q)
                IDLE:     if (!fifo_empty) begin
                              state_d = hit ? D_SETUP : A_SETUP;
                              cnt_d   = '0;
                          end
                A_SETUP:  begin state_d = A_STROBE; cnt_d = CNT_PULSE; end
                A_STROBE: begin state_d = A_WAIT;   cnt_d = CNT_AWAIT; end
                A_WAIT:   begin state_d = D_SETUP;  cnt_d = '0;        end
                D_SETUP:  begin state_d = D_STROBE; cnt_d = CNT_PULSE; end
                D_STROBE: begin state_d = D_WAIT;   cnt_d = CNT_DWAIT; end
                default:  begin state_d = IDLE;     cnt_d = '0;        end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_n_q  <= '1;
            wr_n_q  <= 1'b1;
            a0_q    <= 1'b0;
            d_q     <= '0;
            busy_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_q != IDLE) || !fifo_empty;
            if (pop && !chip_ok(head.chip)) bad_q <= 1'b1;
            // A0/D are only rewritten in setup/strobe, so they hold through waits.
            case (state_q)
                A_SETUP, A_STROBE: begin
                    cs_n_q <= cs_mask(cmd_q.chip);
                    wr_n_q <= (state_q != A_STROBE);
                    a0_q   <= 1'b0;
                    d_q    <= cmd_q.addr;
                end
                D_SETUP, D_STROBE: begin
                    cs_n_q <= cs_mask(cmd_q.chip);
                    wr_n_q <= (state_q != D_STROBE);
                    a0_q   <= 1'b1;
                    d_q    <= cmd_q.data;
                end
                default: begin
                    cs_n_q <= '1;
                    wr_n_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pop) cmd_q <= head;
    end

    assign bus.o_cs_n = cs_n_q;
    assign bus.o_wr_n = wr_n_q;
    assign bus.o_a0   = a0_q;
    assign bus.o_d    = d_q;
    assign o_busy     = busy_q;
    assign o_bad_chip = bad_q;
endmodule
